// File: rtl/mcp3008_sample_collector.sv
// mcp3008_sample_collector
// Brings MCP3008 conversion words from the dclk-domain interface into clk,
// checks the header, and queues {channel, sample} in a show-ahead FIFO.
// Optional per-channel averaging is enabled by defining MCP3008_AVG_EN.
module mcp3008_sample_collector #(
  parameter int NUM_CHANNELS = 3,
  parameter int FIFO_LOG2    = 4,
  parameter int AVG_LOG2     = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        adc_word,
  input  logic               adc_avail,
  output logic               adc_accept,
  input  logic               rd_en,
  output logic [12:0]        rd_data,
  output logic               rd_empty,
  output logic               fifo_full,
  output logic [FIFO_LOG2:0] fifo_level,
  output logic [7:0]         hdr_err_cnt
);

  localparam int DEPTH = 2 ** FIFO_LOG2;

  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;

  state_t                 state_reg, state_next;
  logic                   avail_meta_reg, avail_s_reg;
  logic                   adc_accept_reg;
  logic [FIFO_LOG2:0]     wr_cnt_reg, rd_cnt_reg;
  logic [12:0]            rd_data_reg;
  logic [7:0]             hdr_err_cnt_reg;
  logic [12:0]            mem [DEPTH];

  logic                   push, pop, err_inc;
  logic [12:0]            push_data;
  logic [2:0]             ch_w;
  logic [9:0]             sample_w;
  logic                   hdr_bad;
  logic [FIFO_LOG2-1:0]   wr_addr, rd_addr, rd_addr_next;

  assign ch_w     = adc_word[14:12];
  assign sample_w = adc_word[9:0];
  assign hdr_bad  = !adc_word[15] || (adc_word[11:10] != 2'b00) ||
                    (32'(ch_w) >= NUM_CHANNELS);

  assign fifo_level   = wr_cnt_reg - rd_cnt_reg;
  assign rd_empty     = (fifo_level == '0);
  assign fifo_full    = (fifo_level == (FIFO_LOG2+1)'(DEPTH));
  assign pop          = rd_en && !rd_empty;
  assign wr_addr      = wr_cnt_reg[FIFO_LOG2-1:0];
  assign rd_addr      = rd_cnt_reg[FIFO_LOG2-1:0];
  assign rd_addr_next = rd_addr + 1'b1;

  assign adc_accept   = adc_accept_reg;
  assign rd_data      = rd_data_reg;
  assign hdr_err_cnt  = hdr_err_cnt_reg;

`ifdef MCP3008_AVG_EN
  localparam int ACC_W = 10 + AVG_LOG2;

  logic [ACC_W-1:0]    acc_arr [NUM_CHANNELS];
  logic [AVG_LOG2-1:0] cnt_arr [NUM_CHANNELS];
  logic [ACC_W-1:0]    acc_sel, acc_sum;
  logic [AVG_LOG2-1:0] cnt_sel;
  logic                acc_add, acc_clr, avg_final;

  // Select the accumulator of the channel named in the current word
  always_comb begin
    acc_sel = '0;
    cnt_sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (32'(ch_w) == i) begin
        acc_sel = acc_arr[i];
        cnt_sel = cnt_arr[i];
      end
    end
  end

  assign acc_sum   = acc_sel + ACC_W'(sample_w);
  assign avg_final = (cnt_sel == AVG_LOG2'(2 ** AVG_LOG2 - 1));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_avg
      logic [ACC_W-1:0]    acc_reg;
      logic [AVG_LOG2-1:0] cnt_reg;
      // Per-channel running sum; cleared when its average is emitted
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
          cnt_reg <= '0;
        end else if (32'(ch_w) == gi) begin
          if (acc_clr) begin
            acc_reg <= '0;
            cnt_reg <= '0;
          end else if (acc_add) begin
            acc_reg <= acc_sum;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end
      assign acc_arr[gi] = acc_reg;
      assign cnt_arr[gi] = cnt_reg;
    end
  endgenerate
`endif

  // Next-state and handshake/push decode
  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    push_data  = '0;
    err_inc    = 1'b0;
`ifdef MCP3008_AVG_EN
    acc_add    = 1'b0;
    acc_clr    = 1'b0;
`endif
    case (state_reg)
      IDLE: if (avail_s_reg) state_next = CAPTURE;
      CAPTURE: begin
        if (hdr_bad) begin
          err_inc    = 1'b1;
          state_next = ACK;
`ifdef MCP3008_AVG_EN
        end else if (!avg_final) begin
          acc_add    = 1'b1;
          state_next = ACK;
        end else if (!fifo_full) begin
          push       = 1'b1;
          acc_clr    = 1'b1;
          push_data  = {ch_w, acc_sum[ACC_W-1:AVG_LOG2]};
          state_next = ACK;
        end
`else
        end else if (!fifo_full) begin
          push       = 1'b1;
          push_data  = {ch_w, sample_w};
          state_next = ACK;
        end
`endif
      end
      ACK: if (!avail_s_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, synchroniser, acknowledge and error counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      avail_meta_reg  <= 1'b0;
      avail_s_reg     <= 1'b0;
      adc_accept_reg  <= 1'b0;
      hdr_err_cnt_reg <= '0;
    end else begin
      state_reg       <= state_next;
      avail_meta_reg  <= adc_avail;
      avail_s_reg     <= avail_meta_reg;
      adc_accept_reg  <= (state_next == ACK);
      if (err_inc && hdr_err_cnt_reg != 8'hFF)
        hdr_err_cnt_reg <= hdr_err_cnt_reg + 1'b1;
    end
  end

  // FIFO storage; no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_addr] <= push_data;
  end

  // FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_reg <= '0;
      rd_cnt_reg <= '0;
    end else begin
      if (push) wr_cnt_reg <= wr_cnt_reg + 1'b1;
      if (pop)  rd_cnt_reg <= rd_cnt_reg + 1'b1;
    end
  end

  // Show-ahead head register; bypasses the write when the new entry becomes the head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
    end else if (push && (rd_empty || (pop && fifo_level == (FIFO_LOG2+1)'(1)))) begin
      rd_data_reg <= push_data;
    end else if (pop) begin
      rd_data_reg <= mem[rd_addr_next];
    end
  end

endmodule

// File: tb/tb_mcp3008_sample_collector.sv
// Directed bench for mcp3008_sample_collector (FIFO_LOG2=2 so the full case is reachable).
// Define MCP3008_AVG_EN to run the averaging case instead of the pass-through cases.
module tb_mcp3008_sample_collector;

  logic        clk = 1'b0;
  logic        dclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] adc_word = '0;
  logic        adc_avail = 1'b0;
  logic        adc_accept;
  logic        rd_en = 1'b0;
  logic [12:0] rd_data;
  logic        rd_empty;
  logic        fifo_full;
  logic [2:0]  fifo_level;
  logic [7:0]  hdr_err_cnt;

  int checks = 0;
  int errors = 0;

  mcp3008_sample_collector #(
    .NUM_CHANNELS(3),
    .FIFO_LOG2(2),
    .AVG_LOG2(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .adc_word(adc_word),
    .adc_avail(adc_avail),
    .adc_accept(adc_accept),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_empty(rd_empty),
    .fifo_full(fifo_full),
    .fifo_level(fifo_level),
    .hdr_err_cnt(hdr_err_cnt)
  );

  always #5 clk = ~clk;
  always #23 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic wait_accept(input logic lvl, input string tag);
    for (int i = 0; i < 200 && adc_accept !== lvl; i++) @(negedge clk);
    check(tag, 32'(adc_accept), 32'(lvl));
  endtask

  task automatic start_word(input logic [15:0] w);
    @(posedge dclk);
    adc_word  = w;
    adc_avail = 1'b1;
  endtask

  task automatic end_word();
    wait_accept(1'b1, "accept_high");
    @(posedge dclk);
    adc_avail = 1'b0;
    wait_accept(1'b0, "accept_low");
  endtask

  task automatic send_word(input logic [15:0] w);
    start_word(w);
    end_word();
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_accept"}, 32'(adc_accept), 32'(0));
    check({tag, "_empty"},  32'(rd_empty),   32'(1));
    check({tag, "_full"},   32'(fifo_full),  32'(0));
    check({tag, "_level"},  32'(fifo_level), 32'(0));
    check({tag, "_herr"},   32'(hdr_err_cnt), 32'(0));
    check({tag, "_rdata"},  32'(rd_data),    32'(0));
  endtask

  logic [12:0] exp_t2 [3];
  logic [15:0] bad_words [3];

  initial begin
    exp_t2    = '{13'h0001, 13'h0600, 13'h0BFF};
    bad_words = '{16'h2005, 16'hB805, 16'h8C05};

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

`ifdef MCP3008_AVG_EN
    // T6: ch1 samples 10,11,12,14 -> one push of average 11
    send_word(16'h900A);
    send_word(16'h900B);
    send_word(16'h900C);
    check("t6_no_push_yet", 32'(rd_empty), 32'(1));
    send_word(16'h900E);
    check("t6_level",  32'(fifo_level), 32'(1));
    check("t6_rdata",  32'(rd_data),    32'(13'h040B));
    pop();
    check("t6_empty",  32'(rd_empty),   32'(1));
`else
    // T1: single word ch2, sample 0x3FF
    send_word(16'hA3FF);
    check("t1_rdata", 32'(rd_data),     32'(13'h0BFF));
    check("t1_empty", 32'(rd_empty),    32'(0));
    check("t1_herr",  32'(hdr_err_cnt), 32'(0));
    pop();
    check("t1_empty_after_pop", 32'(rd_empty), 32'(1));

    // T2: three channels, then drain in order
    send_word(16'h8001);
    send_word(16'h9200);
    send_word(16'hA3FF);
    check("t2_level", 32'(fifo_level), 32'(3));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_rdata%0d", i), 32'(rd_data), 32'(exp_t2[i]));
      pop();
      check($sformatf("t2_level%0d", i), 32'(fifo_level), 32'(2 - i));
    end
    check("t2_empty", 32'(rd_empty), 32'(1));

    // T3: fill the 4-entry FIFO, fifth word is back-pressured until a pop
    for (int i = 1; i <= 4; i++) send_word(16'h8000 | 16'(i));
    check("t3_full",  32'(fifo_full),  32'(1));
    check("t3_level", 32'(fifo_level), 32'(4));
    start_word(16'h8005);
    repeat (20) @(negedge clk);
    check("t3_blocked_accept", 32'(adc_accept), 32'(0));
    check("t3_blocked_level",  32'(fifo_level), 32'(4));
    check("t3_head", 32'(rd_data), 32'(13'h0001));
    pop();
    end_word();
    check("t3_level_after", 32'(fifo_level), 32'(4));
    check("t3_full_after",  32'(fifo_full),  32'(1));
    for (int i = 2; i <= 5; i++) begin
      check($sformatf("t3_drain%0d", i), 32'(rd_data), 32'(i));
      pop();
    end
    check("t3_empty", 32'(rd_empty), 32'(1));

    // T4: three bad headers, each acknowledged and counted
    for (int i = 0; i < 3; i++) send_word(bad_words[i]);
    check("t4_herr",  32'(hdr_err_cnt), 32'(3));
    check("t4_empty", 32'(rd_empty),    32'(1));

    // T5: reset while in ACK with adc_avail high
    start_word(16'h9123);
    wait_accept(1'b1, "t5_accept_before_reset");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("t5_reset");
    rst_n = 1'b1;
    end_word();
    check("t5_level", 32'(fifo_level), 32'(1));
    check("t5_rdata", 32'(rd_data),    32'(13'h0523));
    pop();
    check("t5_empty", 32'(rd_empty), 32'(1));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
